ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Instruction prefetch stage between the core's fetch port and the combinational imem.
- Generates sequential fetch addresses to imem and buffers returned {pc, instruction} pairs in a small FIFO.
- Hands entries to the core with a valid/ready handshake.
- Flushes and restarts on a redirect (branch/jump) from the core.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- RESET_PC, 32'hBFC0_0000: first fetch address after reset.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset; state clears on a posedge clk where reset==0.
- redirect_valid  in  1  core requests a fetch restart.
- redirect_pc  in  32  new fetch address, sampled when redirect_valid==1.
- imem_addr  out  32  fetch address to imem; combinational copy of fetch_pc.
- imem_instr  in  32  imem read data for imem_addr, same cycle (combinational memory).
- out_valid  out  1  head entry available.
- out_ready  in  1  core accepts head entry.
- out_pc  out  32  pc of head entry.
- out_instr  out  32  instruction of head entry.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (reset==0 at posedge):
  - fetch_pc<=RESET_PC; count, rd_ptr and wr_ptr <=0.
  - Outputs: out_valid=0; out_pc=0 and out_instr=0 (storage cleared); imem_addr=RESET_PC.
  - Reset overrides every other input in that cycle.
- pop = out_valid && out_ready.
- push = !redirect_valid && (count<DEPTH || pop). A full queue with a same-cycle pop still pushes.
- On push:
  - Entry {fetch_pc, imem_instr} is written at wr_ptr.
  - wr_ptr advances modulo DEPTH.
  - fetch_pc<=fetch_pc+4, 32-bit wrap: 32'hFFFF_FFFC -> 0.
- On pop:
  - rd_ptr advances modulo DEPTH.
  - count<=count+push-pop. Simultaneous push and pop leaves count unchanged.
- out_valid=(count!=0). out_pc and out_instr come combinationally from the storage at rd_ptr.
- Fetch-to-output latency: an instruction fetched in cycle N is visible at the output in cycle N+1 when the queue was empty.
- Redirect (redirect_valid==1, reset==1), highest priority after reset:
  - count<=0, rd_ptr<=wr_ptr.
  - fetch_pc<=redirect_pc with bits [1:0] forced to 0.
  - No push that cycle. A pop in the same cycle is still a legal handshake, but that entry is discarded by the flush.
  - out_valid==0 in the next cycle.
  - The first entry from the new pc is visible 2 cycles after redirect is asserted.
- Full, no pop: fetch_pc holds; imem_addr stays stable.
- Empty: out_valid=0. out_pc and out_instr are don't-care but must not be X after reset.

Optional Feature:
- Macro: IFQ_ALIGN_CHECK_EN.
- Defined:
  - Extra output port misalign (out, 1).
  - A redirect with redirect_pc[1:0]!=0 loads fetch_pc unmasked, sets misalign<=1 and blocks all pushes.
  - misalign clears only on reset or a later redirect with aligned pc.
  - Pops of already-queued entries are unaffected (the flush leaves none).
- Undefined: no misalign port; bits [1:0] are always masked to 0 on redirect.

Test Plan:
- Reset then release, out_ready=1, imem returns pc^32'h1111_0000 -> out_pc sequence BFC00000, BFC00004, BFC00008 from cycle 1 onward, one per cycle; count stays 1.
- out_ready=0 for 10 cycles -> count saturates at 4; imem_addr holds BFC00010. Then out_ready=1 -> entries BFC00000..BFC0000C drain in order with no gap or duplicate.
- Full queue plus a single-cycle pop -> count stays 4; BFC00010 is pushed the same cycle.
- Redirect to 32'h8000_0100 while count=3 -> next cycle out_valid=0 and imem_addr=80000100; the cycle after, out_pc=80000100.
- fetch_pc at FFFFFFFC -> next imem_addr=00000000; out_pc sequence FFFFFFFC, 00000000.
- Assert reset mid-drain with count=2 -> next cycle count=0, out_valid=0, imem_addr=BFC00000.
- IFQ_ALIGN_CHECK_EN: redirect to 32'h0000_0102 -> misalign=1, count stays 0. Then redirect to 0x100 -> misalign=0 and fetch resumes.

Source files
------------

// File: rtl/ifetch_queue_if.sv
// rtl/ifetch_queue_if.sv - redirect, imem and output-stream bundle for ifetch_queue
// Optional misalign signal present when IFQ_ALIGN_CHECK_EN is defined.
interface ifetch_queue_if #(
  parameter int DEPTH = 4
);
  logic                       redirect_valid;
  logic [31:0]                redirect_pc;
  logic [31:0]                imem_addr;
  logic [31:0]                imem_instr;
  logic                       out_valid;
  logic                       out_ready;
  logic [31:0]                out_pc;
  logic [31:0]                out_instr;
  logic [$clog2(DEPTH+1)-1:0] count;
`ifdef IFQ_ALIGN_CHECK_EN
  logic                       misalign;

  modport master (
    input  redirect_valid, redirect_pc, imem_instr, out_ready,
    output imem_addr, out_valid, out_pc, out_instr, count, misalign
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_instr, out_ready,
    input  imem_addr, out_valid, out_pc, out_instr, count, misalign
  );
`else
  modport master (
    input  redirect_valid, redirect_pc, imem_instr, out_ready,
    output imem_addr, out_valid, out_pc, out_instr, count
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_instr, out_ready,
    input  imem_addr, out_valid, out_pc, out_instr, count
  );
`endif
endinterface

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - sequential instruction prefetch FIFO with redirect flush
// Optional IFQ_ALIGN_CHECK_EN adds a misalign flag that blocks fetch after an unaligned redirect.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input logic            clk,
  input logic            reset,
  ifetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          pop;
  logic          push;
  logic          blocked;

`ifdef IFQ_ALIGN_CHECK_EN
  logic misalign_q;
  assign blocked      = misalign_q;
  assign bus.misalign = misalign_q;
`else
  assign blocked = 1'b0;
`endif

  assign bus.out_valid = (count_q != '0);
  assign pop           = bus.out_valid && bus.out_ready;
  // A full queue still accepts a fetch when the head leaves in the same cycle.
  assign push          = !bus.redirect_valid && !blocked && ((count_q < CW'(DEPTH)) || pop);

  assign bus.imem_addr = fetch_pc;
  assign bus.out_pc    = pc_mem[rd_ptr];
  assign bus.out_instr = instr_mem[rd_ptr];
  assign bus.count     = count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
`ifdef IFQ_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else if (bus.redirect_valid) begin
      // Flush: any same-cycle pop is absorbed since rd_ptr jumps to wr_ptr.
      count_q <= '0;
      rd_ptr  <= wr_ptr;
`ifdef IFQ_ALIGN_CHECK_EN
      fetch_pc   <= bus.redirect_pc;
      misalign_q <= |bus.redirect_pc[1:0];
`else
      fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
`endif
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= fetch_pc;
        instr_mem[wr_ptr] <= bus.imem_instr;
        wr_ptr            <= wr_ptr + PW'(1);
        fetch_pc          <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - scoreboard bench for ifetch_queue against a queue-based reference model
// Honours IFQ_ALIGN_CHECK_EN when defined.
module tb_ifetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic reset;

  ifetch_queue_if #(.DEPTH(DEPTH)) bus ();

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Combinational imem: data is a fixed function of the address.
  assign bus.imem_instr = bus.imem_addr ^ 32'h1111_0000;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  int          mcount = 0;
  logic [31:0] mpc    = RESET_PC;
  bit          mmis   = 1'b0;
  bit          live   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rst_n, input bit rdy, input bit rv, input logic [31:0] rpc);
    reset              = rst_n;
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  // Reference model: queue contents, occupancy and next fetch pc per clock edge.
  initial begin : model
    bit pop;
    bit push;
    forever begin
      @(posedge clk);
      if (reset === 1'b0) begin
        exp_q.delete();
        mcount = 0;
        mpc    = RESET_PC;
        mmis   = 1'b0;
        live   = 1'b1;
      end else if (live) begin
        pop = (mcount != 0) && bus.out_ready;
        if (bus.redirect_valid) begin
          exp_q.delete();
          mcount = 0;
`ifdef IFQ_ALIGN_CHECK_EN
          mpc  = bus.redirect_pc;
          mmis = (bus.redirect_pc % 4) != 0;
`else
          mpc = bus.redirect_pc - (bus.redirect_pc % 4);
`endif
        end else begin
          push = !mmis && ((mcount < DEPTH) || pop);
          if (push) begin
            exp_q.push_back({mpc, mpc ^ 32'h1111_0000});
            mpc = mpc + 32'd4;
          end
          mcount = mcount + int'(push) - int'(pop);
        end
      end
    end
  end

  // Monitor: status against the model every cycle, head entry on every handshake.
  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (live) begin
        chk("count", 32'(bus.count), 32'(mcount));
        chk("out_valid", 32'(bus.out_valid), 32'(mcount != 0));
        chk("imem_addr", bus.imem_addr, mpc);
`ifdef IFQ_ALIGN_CHECK_EN
        chk("misalign", 32'(bus.misalign), 32'(mmis));
`endif
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pop_underflow: got handshake expected no entry");
          end else begin
            e = exp_q.pop_front();
            chk("out_pc", bus.out_pc, e[63:32]);
            chk("out_instr", bus.out_instr, e[31:0]);
          end
        end
      end
    end
  end

  initial begin : stimulus
    bit          rst_n;
    bit          rdy;
    bit          rv;
    logic [31:0] rpc;
    int          bias;

    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_imem_addr", bus.imem_addr, RESET_PC);

    // Streaming with ready held high: one entry per cycle, occupancy 1.
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("stream_count", 32'(bus.count), 32'd1);
      chk("stream_pc", bus.out_pc, RESET_PC + 32'(4 * i));
    end

    // Fill to saturation, then a single pop while full.
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (10) tick();
    chk("full_count", 32'(bus.count), 32'd4);
    chk("full_addr", bus.imem_addr, 32'hBFC0_0010);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    chk("full_pop_count", 32'(bus.count), 32'd4);
    chk("full_pop_addr", bus.imem_addr, 32'hBFC0_0014);
    chk("full_pop_head", bus.out_pc, 32'hBFC0_0004);
    repeat (8) tick();

    // Redirect with three entries queued.
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) tick();
    chk("pre_redirect_count", 32'(bus.count), 32'd3);
    drive(1'b1, 1'b1, 1'b1, 32'h8000_0100);
    tick();
    chk("redirect_valid_low", 32'(bus.out_valid), 32'd0);
    chk("redirect_addr", bus.imem_addr, 32'h8000_0100);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    chk("redirect_head", bus.out_pc, 32'h8000_0100);

    // Address wrap at the top of the space.
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    chk("wrap_addr", bus.imem_addr, 32'h0);
    chk("wrap_head0", bus.out_pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_head1", bus.out_pc, 32'h0);

    // Reset in the middle of a drain.
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("mid_count", 32'(bus.count), 32'd2);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_addr", bus.imem_addr, RESET_PC);
    chk("mid_rst_pc", bus.out_pc, 32'h0);

`ifdef IFQ_ALIGN_CHECK_EN
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0102);
    tick();
    chk("mis_flag", 32'(bus.misalign), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (3) begin
      tick();
      chk("mis_count", 32'(bus.count), 32'd0);
    end
    chk("mis_addr", bus.imem_addr, 32'h0000_0102);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    tick();
    chk("mis_clear", 32'(bus.misalign), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    chk("mis_resume_count", 32'(bus.count), 32'd1);
    chk("mis_resume_pc", bus.out_pc, 32'h0000_0100);
`else
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0102);
    tick();
    chk("mask_addr", bus.imem_addr, 32'h0000_0100);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    chk("mask_head", bus.out_pc, 32'h0000_0100);
`endif

    // Randomized traffic with varying backpressure, redirects and rare resets.
    bias = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) bias = $urandom_range(10, 95);
      rst_n = ($urandom_range(0, 299) != 0);
      rdy   = ($urandom_range(0, 99) < bias);
      rv    = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       rpc = $urandom;
        1:       rpc = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
        2:       rpc = $urandom | 32'h1;
        default: rpc = $urandom & 32'hFFFF_FFFC;
      endcase
      drive(rst_n, rdy, rv, rpc);
      tick();
    end

    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
